// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: one priority for all hazards.
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_use_hazard,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       md_start,
  input  logic       md_done,
  output logic       pc_freeze,
  output logic       if_id_freeze,
  output logic       id_ex_freeze,
  output logic       ex_mem_freeze,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_bubble,
  output logic       mem_wb_bubble,
  output logic [1:0] ctrl_state,
  output logic       mem_timeout_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          frz_mem, frz_md, lu_stall, br_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    err_d    = err_q;
    frz_mem  = 1'b0;
    frz_md   = 1'b0;
    lu_stall = 1'b0;
    br_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          frz_mem = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end else if (md_start && !md_done) begin
          frz_md  = 1'b1;
          state_d = MD_WAIT;
        end else if (load_use_hazard) begin
          lu_stall = 1'b1;
        end else if (branch_taken) begin
          br_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_q == WW'(MEM_TIMEOUT)) begin
          // Abort cycle itself is unfrozen; the error is visible next cycle.
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          frz_mem = 1'b1;
          wait_d  = wait_q + WW'(1);
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else begin
          frz_md = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_freeze       = rst_n & (frz_mem | frz_md | lu_stall);
  assign if_id_freeze    = rst_n & (frz_mem | frz_md | lu_stall);
  assign id_ex_freeze    = rst_n & (frz_mem | frz_md);
  assign ex_mem_freeze   = rst_n & frz_mem;
  assign mem_wb_bubble   = rst_n & frz_mem;
  assign ex_mem_bubble   = rst_n & frz_md;
  assign id_ex_flush     = rst_n & lu_stall;
  assign if_id_flush     = rst_n & br_flush;
  assign ctrl_state      = rst_n ? state_q : 2'd0;
  assign mem_timeout_err = rst_n & err_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_freeze && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if ((if_id_flush || id_ex_flush) && !(&flush_q))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = rst_n ? stall_q : '0;
  assign flush_count  = rst_n ? flush_q : '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed plus random bench for pipeline_stall_controller.
// Reference model tracks mode / elapsed wait as plain integers.
module tb_pipeline_stall_controller;

  localparam int TO = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n, lu_i, br_i, mr_i, rdy_i, ms_i, md_i;
  logic pc_f, ifid_f, idex_f, exmem_f;
  logic ifid_fl, idex_fl, exmem_b, memwb_b;
  logic [1:0] st;
  logic err;
`ifdef STALL_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  pipeline_stall_controller #(
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_use_hazard(lu_i),
    .branch_taken(br_i),
    .mem_req(mr_i),
    .mem_ready(rdy_i),
    .md_start(ms_i),
    .md_done(md_i),
    .pc_freeze(pc_f),
    .if_id_freeze(ifid_f),
    .id_ex_freeze(idex_f),
    .ex_mem_freeze(exmem_f),
    .if_id_flush(ifid_fl),
    .id_ex_flush(idex_fl),
    .ex_mem_bubble(exmem_b),
    .mem_wb_bubble(memwb_b),
    .ctrl_state(st),
    .mem_timeout_err(err)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int frz_seen = 0;

  // model: mode 0 run, 1 memory wait, 2 mult/div wait
  int m_mode = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  longint unsigned m_stall = 0;
  longint unsigned m_flush = 0;

  task automatic apply(input bit r, input bit lu, input bit br,
                       input bit mr, input bit rdy,
                       input bit ms, input bit md);
    bit [7:0] e;
    bit [7:0] obs;
    int nm, nc;
    bit ne;
    @(negedge clk);
    rst_n = r; lu_i = lu; br_i = br;
    mr_i = mr; rdy_i = rdy; ms_i = ms; md_i = md;
    #1;
    e = 8'b0; nm = m_mode; nc = 0; ne = m_err;
    if (!r) begin
      nm = 0; ne = 1'b0;
    end else if (m_mode == 0) begin
      if (mr && !rdy) begin
        e = 8'b1111_0001; nm = 1; nc = 1;
      end else if (ms && !md) begin
        e = 8'b1110_0010; nm = 2;
      end else if (lu) e = 8'b1100_0100;
      else if (br) e = 8'b0000_1000;
    end else if (m_mode == 1) begin
      if (rdy) nm = 0;
      else if (m_cnt == TO) begin
        nm = 0; ne = 1'b1;
      end else begin
        e = 8'b1111_0001; nc = m_cnt + 1;
      end
    end else begin
      if (md) nm = 0;
      else e = 8'b1110_0010;
    end
    obs = {pc_f, ifid_f, idex_f, exmem_f,
           ifid_fl, idex_fl, exmem_b, memwb_b};
    if (pc_f === 1'b1) frz_seen++;
    vec++;
    assert (obs === e) else begin
      miss++;
      $error("FAIL ctl obs=%b exp=%b t=%0t", obs, e, $time);
    end
    vec++;
    assert (st === 2'(r ? m_mode : 0)) else begin
      miss++;
      $error("FAIL state obs=%0d exp=%0d t=%0t", st, r ? m_mode : 0, $time);
    end
    vec++;
    assert (err === (r & m_err)) else begin
      miss++;
      $error("FAIL err obs=%b exp=%b t=%0t", err, r & m_err, $time);
    end
`ifdef STALL_PERF_CNT_EN
    vec++;
    assert (stall_cycles === CW'(r ? m_stall : 0)) else begin
      miss++;
      $error("FAIL stall_cnt obs=%0d exp=%0d", stall_cycles, r ? m_stall : 0);
    end
    vec++;
    assert (flush_count === CW'(r ? m_flush : 0)) else begin
      miss++;
      $error("FAIL flush_cnt obs=%0d exp=%0d", flush_count, r ? m_flush : 0);
    end
`endif
    @(posedge clk);
    if (!r) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e[7]) m_stall++;
      if (e[3] || e[2]) m_flush++;
    end
    m_mode = nm; m_cnt = nc; m_err = ne;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lu_i = 1'b1; br_i = 1'b1;
    mr_i = 1'b1; rdy_i = 1'b1; ms_i = 1'b1; md_i = 1'b1;
    // reset with all inputs high
    repeat (3) apply(0, 1, 1, 1, 1, 1, 1);
    apply(1, 0, 0, 0, 0, 0, 0);
    // load-use with branch, then branch alone
    apply(1, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 0, 0);
    // memory wait, ready on 4th cycle
    frz_seen = 0;
    repeat (3) apply(1, 0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 0, 0);
    vec++;
    assert (frz_seen === 3) else begin
      miss++;
      $error("FAIL mem_frz obs=%0d exp=3", frz_seen);
    end
    // timeout
    frz_seen = 0;
    repeat (TO + 1) apply(1, 0, 0, 1, 0, 0, 0);
    vec++;
    assert (frz_seen === TO) else begin
      miss++;
      $error("FAIL to_frz obs=%0d exp=%0d", frz_seen, TO);
    end
    repeat (3) apply(1, 0, 0, 0, 0, 0, 0);
    vec++;
    assert (err === 1'b1) else begin
      miss++;
      $error("FAIL to_sticky obs=%b exp=1", err);
    end
    // memory and mult/div together
    repeat (2) apply(1, 0, 0, 1, 0, 1, 0);
    apply(1, 0, 0, 1, 1, 1, 0);
    repeat (3) apply(1, 0, 0, 0, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 1, 1);
    apply(1, 0, 0, 0, 0, 0, 0);
    // reset during memory wait, then fresh access
    repeat (2) apply(1, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 0);
    frz_seen = 0;
    repeat (3) apply(1, 0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 0, 0);
    vec++;
    assert (frz_seen === 3) else begin
      miss++;
      $error("FAIL restart_frz obs=%0d exp=3", frz_seen);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
